// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core front end.
//   PC_W         - program counter / instruction address width
//   IW_DEF       - default instruction word width
//   RESET_PC_DEF - default PC loaded on reset
//   FETCH/EXEC/HALT - fetch sequencer state encoding
package cpu_pkg;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned IW_DEF = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

endpackage

// File: rtl/fetch_timer.sv
// Counts FETCH cycles spent waiting for a ROM ack.
//   clk_i     - system clock
//   rst_ni    - asynchronous active-low reset
//   clear_i   - restart the count at zero (has priority over en_i)
//   en_i      - one more cycle spent waiting
//   expired_o - the current waiting cycle is the Limit-th one
module fetch_timer
    import cpu_pkg::*;
#(
    parameter int unsigned Limit = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LastCnt = 8'(Limit - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Combinational so the owner can act on the same edge the count would reach Limit.
    assign expired_o = en_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter register and instruction-fetch sequencer.
//   clk_i/rst_ni        - clock, asynchronous active-low reset
//   pc_o                - current PC (to incrementer); imem_addr_o mirrors it
//   pc_plus_1_i         - incremented PC from the incrementer
//   br_taken_i/br_target_i, jmp_i/jmp_target_i, halt_i - control flow, sampled with step
//   step_i/stall_i      - instruction complete / hold-off
//   imem_req_o/imem_ack_i/imem_data_i - ROM fetch handshake
//   ir_o/ir_valid_o     - latched instruction and one-cycle update pulse
//   halted_o/fetch_err_o - halted status and sticky fetch timeout flag
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned     IW          = IW_DEF,
    parameter int unsigned     ACK_TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [PC_W-1:0] pc_o,
    input  logic [PC_W-1:0] pc_plus_1_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jmp_target_i,
    input  logic            step_i,
    input  logic            stall_i,
    input  logic            halt_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [IW-1:0]   imem_data_i,
    output logic [IW-1:0]   ir_o,
    output logic            ir_valid_o,
    output logic            halted_o,
    output logic            fetch_err_o
);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            req_q, req_d;
    logic            err_q, err_d;

    logic in_fetch;
    logic accept;
    logic timer_expired;

    assign in_fetch = (state_q == FETCH);
    // req_q is low for the first FETCH cycle after reset, so an early ack is not taken.
    assign accept   = in_fetch && req_q && imem_ack_i;

    fetch_timer #(
        .Limit (ACK_TIMEOUT)
    ) u_fetch_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (!in_fetch || accept),
        .en_i      (in_fetch && req_q && !imem_ack_i),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        req_d      = req_q;
        err_d      = err_q;

        case (state_q)
            FETCH: begin
                if (accept) begin
                    ir_d       = imem_data_i;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    state_d    = EXEC;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = HALT;
                end else begin
                    req_d = 1'b1;
                end
            end
            EXEC: begin
                req_d = 1'b0;
                if (step_i && !stall_i) begin
                    if (halt_i) begin
                        state_d = HALT;
                    end else begin
                        // Priority: jump over taken branch over sequential.
                        if (jmp_i) begin
                            pc_d = jmp_target_i;
                        end else if (br_taken_i) begin
                            pc_d = br_target_i;
                        end else begin
                            pc_d = pc_plus_1_i;
                        end
                        // Request goes out in the very next cycle for a 2-cycle turnaround.
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                req_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
            err_q      <= err_d;
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;
    assign imem_req_o  = req_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;
    assign halted_o    = (state_q == HALT);
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed test-plan scenarios with literal
// expectations, then randomized episodes, all compared every cycle against a
// transaction-level model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc;
    logic [7:0]  pc_plus_1;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        jmp = 1'b0;
    logic [7:0]  jmp_target = 8'h00;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        fetch_err;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC    (8'h00),
        .IW          (16),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_o         (pc),
        .pc_plus_1_i  (pc_plus_1),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .step_i       (step),
        .stall_i      (stall),
        .halt_i       (halt),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_data_i  (imem_data),
        .ir_o         (ir),
        .ir_valid_o   (ir_valid),
        .halted_o     (halted),
        .fetch_err_o  (fetch_err)
    );

    // ---------------- behavioural model ----------------
    // Phase: 0 = waiting for an instruction, 1 = executing it, 2 = stopped.
    int          m_phase;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_irv;
    logic        m_req;
    logic        m_err;
    int          m_wait;

    // The bench plays the incrementer.
    assign pc_plus_1 = m_pc + 8'd1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_pc    <= 8'h00;
            m_ir    <= 16'h0000;
            m_irv   <= 1'b0;
            m_req   <= 1'b0;
            m_err   <= 1'b0;
            m_wait  <= 0;
        end else begin
            m_irv <= 1'b0;
            if (m_phase == 0) begin
                if (!m_req) begin
                    m_req <= 1'b1;
                end else if (imem_ack) begin
                    m_ir    <= imem_data;
                    m_irv   <= 1'b1;
                    m_req   <= 1'b0;
                    m_phase <= 1;
                    m_wait  <= 0;
                end else if (m_wait + 1 >= 15) begin
                    m_err   <= 1'b1;
                    m_req   <= 1'b0;
                    m_phase <= 2;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (m_phase == 1) begin
                if (step && !stall) begin
                    if (halt) begin
                        m_phase <= 2;
                    end else begin
                        m_pc    <= jmp ? jmp_target : (br_taken ? br_target : pc_plus_1);
                        m_phase <= 0;
                        m_req   <= 1'b1;
                        m_wait  <= 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        vectors++;
        if (pc !== m_pc || imem_addr !== m_pc || imem_req !== m_req || ir !== m_ir ||
            ir_valid !== m_irv || halted !== (m_phase == 2) || fetch_err !== m_err) begin
            errors++;
            $display("FAIL model t=%0t got pc=%h addr=%h req=%b ir=%h irv=%b hlt=%b err=%b want pc=%h req=%b ir=%h irv=%b hlt=%b err=%b",
                     $time, pc, imem_addr, imem_req, ir, ir_valid, halted, fetch_err,
                     m_pc, m_req, m_ir, m_irv, (m_phase == 2), m_err);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_ctl();
        step = 1'b0; stall = 1'b0; halt = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    endtask

    // Zero-wait ack of the pending fetch; leaves the unit in EXEC.
    task automatic fetch_now(input logic [15:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        cyc();
        imem_ack = 1'b0;
        chk("ir_after_fetch", {16'h0, ir}, {16'h0, data});
        chk("irv_pulse", {31'h0, ir_valid}, 32'h1);
        cyc();
        chk("irv_drop", {31'h0, ir_valid}, 32'h0);
    endtask

    task automatic do_step(input logic j, input logic [7:0] jt, input logic b,
                           input logic [7:0] bt, input logic [7:0] exp_pc);
        step = 1'b1; jmp = j; jmp_target = jt; br_taken = b; br_target = bt;
        cyc();
        clear_ctl();
        chk("step_pc", {24'h0, pc}, {24'h0, exp_pc});
        chk("step_req", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic reset_unit();
        clear_ctl();
        imem_ack = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [15:0] last_ir;

        // Reset and first zero-wait fetch.
        cyc();
        chk("rst_pc", {24'h0, pc}, 32'h00);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", {24'h0, imem_addr}, 32'h00);
        fetch_now(16'hA55A);
        chk("exec_no_req", {31'h0, imem_req}, 32'h0);

        // Sequential run, then wrap passthrough.
        for (int i = 1; i <= 4; i++) begin
            do_step(1'b0, 8'h00, 1'b0, 8'h00, 8'(i));
            fetch_now(16'(16'h1000 + i));
        end
        do_step(1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF);
        fetch_now(16'h00FF);
        do_step(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        fetch_now(16'h0100);

        // Jump beats branch; branch alone.
        do_step(1'b1, 8'h40, 1'b1, 8'h20, 8'h40);
        fetch_now(16'h4040);
        do_step(1'b0, 8'h40, 1'b1, 8'h20, 8'h20);
        fetch_now(16'h2020);

        // Stalled step is held off.
        step = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", {24'h0, pc}, 32'h20);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        cyc();
        clear_ctl();
        chk("unstall_pc", {24'h0, pc}, 32'h21);
        fetch_now(16'h2121);

        // Ack timeout: 15 waiting edges, the 15th declares the error.
        do_step(1'b0, 8'h00, 1'b0, 8'h00, 8'h22);
        for (int i = 0; i < 14; i++) cyc();
        chk("pre_timeout_err", {31'h0, fetch_err}, 32'h0);
        cyc();
        chk("timeout_err", {31'h0, fetch_err}, 32'h1);
        chk("timeout_halted", {31'h0, halted}, 32'h1);
        chk("timeout_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1; imem_data = 16'hFFFF;
        cyc();
        cyc();
        imem_ack = 1'b0;
        chk("late_ack_ir", {16'h0, ir}, 32'h2121);

        // Halt instruction.
        reset_unit();
        fetch_now(16'h0B0B);
        step = 1'b1; halt = 1'b1;
        cyc();
        clear_ctl();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_pc", {24'h0, pc}, 32'h00);
        chk("halt_err", {31'h0, fetch_err}, 32'h0);

        // Async reset while a fetch is pending.
        reset_unit();
        do_step(1'b1, 8'h33, 1'b0, 8'h00, 8'h00);
        fetch_now(16'h3333);
        do_step(1'b1, 8'h77, 1'b0, 8'h00, 8'h77);
        imem_ack = 1'b1; imem_data = 16'hDEAD;
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'h0, imem_req}, 32'h0);
        chk("async_pc", {24'h0, pc}, 32'h00);
        chk("async_ir", {16'h0, ir}, 32'h0000);
        imem_ack = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc();
        chk("refetch_req", {31'h0, imem_req}, 32'h1);
        chk("refetch_addr", {24'h0, imem_addr}, 32'h00);
        fetch_now(16'hC0DE);

        // Randomized episodes; the last one starves acks to provoke timeouts.
        for (int ep = 0; ep < 6; ep++) begin
            reset_unit();
            for (int n = 0; n < 400; n++) begin
                imem_ack   = ($urandom_range(99) < ((ep == 5) ? 4 : 65));
                imem_data  = 16'($urandom);
                step       = $urandom_range(1);
                stall      = ($urandom_range(99) < 30);
                halt       = ($urandom_range(99) < 2);
                jmp        = ($urandom_range(99) < 20);
                jmp_target = 8'($urandom);
                br_taken   = ($urandom_range(99) < 30);
                br_target  = 8'($urandom);
                cyc();
            end
        end

        clear_ctl();
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
